// File: rtl/burst_ram_pkg.sv
// burst_ram_pkg: shared command codes and arbiter state encodings for the BurstRAM arbiter
//   BR_CMD_READ / BR_CMD_WRITE : values of the 1-bit cmd field
//   br_state_t                 : arbiter FSM states
package burst_ram_pkg;

    localparam logic BR_CMD_READ  = 1'b0;
    localparam logic BR_CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RD_BURST,
        ST_WR_BURST,
        ST_DRAIN
    } br_state_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick between requesters
//   req[1:0]   in  : request levels of master 1 and master 0
//   last_grant in  : master that most recently started a burst
//   win        out : winning master index (only meaningful when req != 0)
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       win
);

    always_comb win = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: two-master burst arbiter in front of a single BurstRAM port (clk_ram domain)
//   clk, rst                         : clock, synchronous active-high reset
//   mN_req/cmd/cmd_en/addr           : master N request level and command
//   mN_wr_data/data_mask             : master N write beat and byte mask
//   mN_rd_data/rd_data_valid         : read beat (broadcast) and per-master valid
//   mN_busy                          : master N must not strobe cmd_en while high
//   ram_cmd/cmd_en/addr/wr_data/mask : muxed command and write data to BurstRAM
//   ram_rd_data/rd_data_valid/busy   : read beats and busy from BurstRAM
module burst_ram_arbiter
    import burst_ram_pkg::*;
#(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 m0_req,
    input  logic                                 m0_cmd,
    input  logic                                 m0_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        m0_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   m0_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] m0_data_mask,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   m0_rd_data,
    output logic                                 m0_rd_data_valid,
    output logic                                 m0_busy,
    input  logic                                 m1_req,
    input  logic                                 m1_cmd,
    input  logic                                 m1_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        m1_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   m1_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] m1_data_mask,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   m1_rd_data,
    output logic                                 m1_rd_data_valid,
    output logic                                 m1_busy,
    output logic                                 ram_cmd,
    output logic                                 ram_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        ram_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   ram_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] ram_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   ram_rd_data,
    input  logic                                 ram_rd_data_valid,
    input  logic                                 ram_busy
);

    localparam int CW = RAM_BURST_DATA_COUNT > 1 ? $clog2(RAM_BURST_DATA_COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(RAM_BURST_DATA_COUNT - 1);
    // beat 0 rides with cmd_en, so the write phase ends one count earlier than a read
    localparam logic [CW-1:0] LAST_WR = CW'(RAM_BURST_DATA_COUNT > 1 ? RAM_BURST_DATA_COUNT - 2 : 0);

    br_state_t state, state_n;
    logic g, g_n, last_grant, last_grant_n, pick;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic sel_req, sel_cmd, sel_cmd_en, owns, accept, grant_busy, rd_fwd;
    logic [RAM_DEPTH_BITWIDTH-1:0] sel_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] sel_wr_data;
    logic [RAM_BURST_DATA_BITWIDTH/8-1:0] sel_mask;

    rr_pick2 u_pick (
        .req       ({m1_req, m0_req}),
        .last_grant(last_grant),
        .win       (pick)
    );

    always_comb begin
        sel_req     = g ? m1_req : m0_req;
        sel_cmd     = g ? m1_cmd : m0_cmd;
        sel_cmd_en  = g ? m1_cmd_en : m0_cmd_en;
        sel_addr    = g ? m1_addr : m0_addr;
        sel_wr_data = g ? m1_wr_data : m0_wr_data;
        sel_mask    = g ? m1_data_mask : m0_data_mask;
        owns        = state == ST_GRANT || state == ST_WR_BURST;
        accept      = !rst && state == ST_GRANT && sel_cmd_en && !ram_busy;
        cnt_inc     = cnt == LAST ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            g          <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            g          <= g_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        g_n          = g;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        case (state)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    state_n = ST_GRANT;
                    g_n     = pick;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    last_grant_n = g;
                    cnt_n        = '0;
                    state_n      = sel_cmd == BR_CMD_READ ? ST_RD_BURST :
                                   RAM_BURST_DATA_COUNT == 1 ? ST_DRAIN : ST_WR_BURST;
                end else if (!sel_req) begin
                    state_n = ST_IDLE;
                end
            end
            ST_WR_BURST: begin
                cnt_n = cnt_inc;
                if (cnt == LAST_WR) state_n = ST_DRAIN;
            end
            ST_RD_BURST: begin
                if (ram_rd_data_valid) begin
                    cnt_n = cnt_inc;
                    if (cnt == LAST) state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!ram_busy) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // rst gates the outputs directly because the state register only clears at the edge
    always_comb begin
        grant_busy       = rst || state != ST_GRANT ? 1'b1 : ram_busy;
        m0_busy          = g ? 1'b1 : grant_busy;
        m1_busy          = g ? grant_busy : 1'b1;
        rd_fwd           = !rst && state == ST_RD_BURST && ram_rd_data_valid;
        m0_rd_data_valid = rd_fwd && !g;
        m1_rd_data_valid = rd_fwd && g;
        m0_rd_data       = ram_rd_data;
        m1_rd_data       = ram_rd_data;
        ram_cmd_en       = accept;
        ram_cmd          = owns ? sel_cmd : BR_CMD_READ;
        ram_addr         = owns ? sel_addr : '0;
        ram_wr_data      = owns ? sel_wr_data : '0;
        ram_data_mask    = owns ? sel_mask : '0;
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter: self-checking bench for burst_ram_arbiter (vector table plus scoreboarded bursts)
module tb_burst_ram_arbiter;
    import burst_ram_pkg::*;

    logic clk = 0, rst = 1;
    logic m0_req = 0, m0_cmd = 0, m0_cmd_en = 0, m1_req = 0, m1_cmd = 0, m1_cmd_en = 0;
    logic [3:0] m0_addr = 0, m1_addr = 0, ram_addr;
    logic [63:0] m0_wr_data = 0, m1_wr_data = 0, ram_wr_data, m0_rd_data, m1_rd_data, ram_rd_data = 0;
    logic [7:0] m0_data_mask = 0, m1_data_mask = 0, ram_data_mask;
    logic m0_rd_data_valid, m1_rd_data_valid, m0_busy, m1_busy, ram_cmd, ram_cmd_en;
    logic ram_rd_data_valid = 0, ram_busy = 0;

    always #5 clk = ~clk;

    burst_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_cmd_en(m0_cmd_en), .m0_addr(m0_addr),
        .m0_wr_data(m0_wr_data), .m0_data_mask(m0_data_mask), .m0_rd_data(m0_rd_data),
        .m0_rd_data_valid(m0_rd_data_valid), .m0_busy(m0_busy),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_cmd_en(m1_cmd_en), .m1_addr(m1_addr),
        .m1_wr_data(m1_wr_data), .m1_data_mask(m1_data_mask), .m1_rd_data(m1_rd_data),
        .m1_rd_data_valid(m1_rd_data_valid), .m1_busy(m1_busy),
        .ram_cmd(ram_cmd), .ram_cmd_en(ram_cmd_en), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
        .ram_data_mask(ram_data_mask), .ram_rd_data(ram_rd_data),
        .ram_rd_data_valid(ram_rd_data_valid), .ram_busy(ram_busy)
    );

    typedef struct packed {logic first; logic cmd; logic [3:0] addr; logic [63:0] data; logic [7:0] mask;} cmd_t;
    typedef struct packed {logic m; logic [63:0] data;} beat_t;
    typedef struct packed {logic rst, r0, r1, e0, e1, rb, rv, b0, b1, ce;} vec_t;

    cmd_t cq[$];
    beat_t bq[$];
    int n_cmp = 0, n_fail = 0, wr_left = 0;
    vec_t tv[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic busy_is(input string nm, input logic e0, input logic e1);
        #2;
        chk({nm, "_m0_busy"}, m0_busy, e0);
        chk({nm, "_m1_busy"}, m1_busy, e1);
    endtask

    task automatic issue(input logic m, input logic cmd, input logic [3:0] a, input logic [63:0] d);
        if (m) begin
            m1_cmd = cmd; m1_addr = a; m1_wr_data = d; m1_data_mask = 8'hFF; m1_cmd_en = 1;
        end else begin
            m0_cmd = cmd; m0_addr = a; m0_wr_data = d; m0_data_mask = 8'hFF; m0_cmd_en = 1;
        end
        cq.push_back('{1'b1, cmd, a, d, 8'hFF});
        busy_is("issue", m, !m);
        step();
        m0_cmd_en = 0;
        m1_cmd_en = 0;
        if (m) m1_req = 0;
        else m0_req = 0;
        ram_busy = 1;
    endtask

    task automatic read_beats(input logic m, input logic [63:0] mul);
        for (int i = 0; i < 4; i++) begin
            ram_rd_data = mul * 64'(i + 1);
            ram_rd_data_valid = 1;
            bq.push_back('{m, mul * 64'(i + 1)});
            step();
        end
        ram_rd_data_valid = 0;
    endtask

    task automatic drain();
        busy_is("drain", 1, 1);
        ram_busy = 0;
        step();
    endtask

    always @(negedge clk) begin
        cmd_t c;
        beat_t b;
        if (m0_rd_data_valid || m1_rd_data_valid) begin
            if (bq.size() == 0) chk("rd_valid_unexpected", {m1_rd_data_valid, m0_rd_data_valid}, 0);
            else begin
                b = bq.pop_front();
                chk("rd_valid_m0", m0_rd_data_valid, !b.m);
                chk("rd_valid_m1", m1_rd_data_valid, b.m);
                chk("rd_data", b.m ? m1_rd_data : m0_rd_data, b.data);
            end
        end
        if (ram_cmd_en) begin
            if (cq.size() == 0 || wr_left != 0) chk("cmd_unexpected", ram_cmd_en, 0);
            else begin
                c = cq.pop_front();
                chk("cmd_kind", c.first, 1);
                chk("cmd", ram_cmd, c.cmd);
                chk("cmd_addr", ram_addr, c.addr);
                chk("cmd_wdata", ram_wr_data, c.data);
                chk("cmd_mask", ram_data_mask, c.mask);
                wr_left = c.cmd == BR_CMD_WRITE ? 3 : 0;
            end
        end else if (wr_left > 0) begin
            if (cq.size() == 0) chk("wr_beat_missing", 1, 0);
            else begin
                c = cq.pop_front();
                chk("wr_beat_data", ram_wr_data, c.data);
                chk("wr_beat_mask", ram_data_mask, c.mask);
            end
            wr_left--;
        end
        if (rst) wr_left = 0;
    end

    initial begin
        //          rst r0 r1 e0 e1 rb rv  b0 b1 ce
        tv[0]  = '{1, 0, 0, 0, 0, 0, 0,  1, 1, 0};
        tv[1]  = '{1, 1, 1, 1, 0, 0, 0,  1, 1, 0};
        tv[2]  = '{0, 1, 1, 0, 0, 0, 0,  1, 1, 0};
        tv[3]  = '{0, 1, 1, 1, 0, 1, 0,  1, 1, 0};
        tv[4]  = '{0, 1, 1, 0, 1, 0, 1,  0, 1, 0};
        tv[5]  = '{0, 0, 1, 0, 0, 0, 0,  0, 1, 0};
        tv[6]  = '{0, 0, 1, 0, 0, 0, 0,  1, 1, 0};
        tv[7]  = '{0, 1, 1, 1, 0, 0, 0,  1, 0, 0};
        tv[8]  = '{0, 1, 0, 0, 0, 0, 0,  1, 0, 0};
        tv[9]  = '{0, 1, 1, 0, 0, 0, 0,  1, 1, 0};
        tv[10] = '{0, 1, 1, 0, 0, 0, 0,  0, 1, 0};
        tv[11] = '{0, 0, 0, 0, 0, 0, 0,  0, 1, 0};
        tv[12] = '{0, 0, 0, 0, 0, 0, 0,  1, 1, 0};
        ram_rd_data = 64'hDEAD;
        for (int i = 0; i < 13; i++) begin
            step();
            rst = tv[i].rst; m0_req = tv[i].r0; m1_req = tv[i].r1;
            m0_cmd_en = tv[i].e0; m1_cmd_en = tv[i].e1;
            ram_busy = tv[i].rb; ram_rd_data_valid = tv[i].rv;
            #2;
            chk($sformatf("vec%0d_m0_busy", i), m0_busy, tv[i].b0);
            chk($sformatf("vec%0d_m1_busy", i), m1_busy, tv[i].b1);
            chk($sformatf("vec%0d_cmd_en", i), ram_cmd_en, tv[i].ce);
        end
        step();
        m0_req = 0; m1_req = 0; m0_cmd_en = 0; m1_cmd_en = 0; ram_busy = 0; ram_rd_data_valid = 0;

        // m0 read burst at 3, beats 0x11..0x44
        m0_req = 1;
        busy_is("a_idle", 1, 1);
        step();
        issue(0, BR_CMD_READ, 4'h3, 64'h0);
        read_beats(0, 64'h11);
        drain();
        m0_req = 1;
        busy_is("a_back_idle", 1, 1);
        step();
        busy_is("a_regrant", 0, 1);
        m0_req = 0;
        step();

        // tie after reset goes to m0, next tie to m1 which then writes while m0 waits
        rst = 1;
        step();
        rst = 0;
        m0_req = 1; m1_req = 1;
        busy_is("b_idle", 1, 1);
        step();
        m1_req = 0;
        issue(0, BR_CMD_READ, 4'h1, 64'h0);
        read_beats(0, 64'h0101_0101);
        drain();
        m0_req = 1; m1_req = 1;
        step();
        issue(1, BR_CMD_WRITE, 4'h7, 64'hA0);
        for (int i = 1; i < 4; i++) begin
            m1_wr_data = 64'hA0 + 64'(i);
            cq.push_back('{1'b0, 1'b1, 4'h7, 64'hA0 + 64'(i), 8'hFF});
            m0_cmd_en = i != 2;
            busy_is("wr", 1, 1);
            step();
        end
        m0_cmd_en = 1;
        drain();

        // m0 granted after drain; RAM busy holds the command off for 5 cycles
        ram_busy = 1;
        busy_is("c_idle", 1, 1);
        step();
        for (int k = 0; k < 5; k++) begin
            busy_is("rb_hold", 1, 1);
            step();
        end
        ram_busy = 0;
        issue(0, BR_CMD_READ, 4'h5, 64'h0);

        // reset after 2 beats: remaining beats dropped, then m1 is served
        for (int i = 0; i < 2; i++) begin
            ram_rd_data = 64'h55 * 64'(i + 1);
            ram_rd_data_valid = 1;
            bq.push_back('{1'b0, 64'h55 * 64'(i + 1)});
            step();
        end
        rst = 1; m0_req = 0; ram_rd_data = 64'h55 * 3;
        busy_is("rst", 1, 1);
        chk("rst_cmd_en", ram_cmd_en, 0);
        step();
        rst = 0; ram_rd_data = 64'h55 * 4; m1_req = 1; ram_busy = 0;
        busy_is("post_rst", 1, 1);
        step();
        ram_rd_data_valid = 0;
        issue(1, BR_CMD_READ, 4'h9, 64'h0);
        read_beats(1, 64'h1000);
        drain();
        step();
        step();
        chk("rd_queue_empty", 64'(bq.size()), 0);
        chk("cmd_queue_empty", 64'(cq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_ram_arbiter.md
Name: burst_ram_arbiter

Overview:
- Two-master arbiter between the cache side and the single BurstRAM port.
- Master 0 is the instruction cache (read bursts only). Master 1 is the data-side cache (read and write bursts).
- Grants one master at a time and holds the grant for a whole burst.
- Muxes command, address and write data to the RAM. Routes rd_data_valid only to the owning master.
- Runs in the clk_ram domain.

Parameters:
- RAM_DEPTH_BITWIDTH, 4, burst address width.
- RAM_BURST_DATA_BITWIDTH, 64, bits per beat.
- RAM_BURST_DATA_COUNT, 4, beats per burst (read or write).

Ports:
- clk  in  1  clock (clk_ram domain).
- rst  in  1  reset, synchronous, active-high.
- mN_req  in  1  master N (N=0,1) requests the RAM; level, held until its burst is issued.
- mN_cmd  in  1  0=read, 1=write (m0 always drives 0).
- mN_cmd_en  in  1  command strobe; valid only while mN_busy is low.
- mN_addr  in  RAM_DEPTH_BITWIDTH  burst address.
- mN_wr_data  in  RAM_BURST_DATA_BITWIDTH  write beat.
- mN_data_mask  in  RAM_BURST_DATA_BITWIDTH/8  byte mask for the beat.
- mN_rd_data  out  RAM_BURST_DATA_BITWIDTH  read beat (broadcast).
- mN_rd_data_valid  out  1  read beat valid for master N.
- mN_busy  out  1  high = master N must not issue cmd_en.
- ram_cmd, ram_cmd_en, ram_addr, ram_wr_data, ram_data_mask  out  (widths as master)  to BurstRAM.
- ram_rd_data  in  RAM_BURST_DATA_BITWIDTH  from BurstRAM.
- ram_rd_data_valid  in  1  from BurstRAM.
- ram_busy  in  1  from BurstRAM.

Behaviour:
- States:
  - IDLE: no owner.
  - GRANT: owner g, waiting for its cmd_en.
  - RD_BURST: counting read beats.
  - WR_BURST: sending the remaining write beats.
  - DRAIN: waiting for ram_busy low.
- Registers: state, grant g, last_grant, beat counter (clog2(COUNT) bits). All outputs are combinational from these registers and the inputs.
- Reset (rst=1 at a clk edge):
  - state=IDLE, last_grant=1, so m0 wins the first tie. Counter=0.
  - Every cycle rst is high: mN_busy=1, ram_cmd_en=0, mN_rd_data_valid=0.
- IDLE:
  - One req high: grant that master, go to GRANT next cycle.
  - Both high: grant the master != last_grant (round-robin).
  - None high: stay in IDLE.
- GRANT:
  - mg_busy = ram_busy. The other master's busy = 1.
  - ram_cmd_en = mg_cmd_en & !ram_busy.
  - On an accepted cmd_en: last_grant<=g. Go to RD_BURST if cmd=0. If cmd=1, go to WR_BURST, or to DRAIN when COUNT=1. Counter=0.
  - mg_req low with no cmd_en: back to IDLE; last_grant unchanged.
- Latency: req at cycle t gives busy low at t+1. Earliest accepted cmd_en is at t+1.
- WR_BURST:
  - Beat 0 travels with cmd_en. Beats 1..COUNT-1 are taken from mg_wr_data / mg_data_mask on consecutive cycles.
  - The counter increments every cycle. After beat COUNT-1, go to DRAIN.
  - The master must supply beats back-to-back; the arbiter does not stall.
- RD_BURST:
  - ram_rd_data_valid is forwarded to mg_rd_data_valid only. The other master sees 0.
  - The counter increments per valid beat. On the COUNT-th beat, go to DRAIN.
- DRAIN: when ram_busy=0, go to IDLE. A new grant is earliest the following cycle.
- Mux outputs: ram_cmd, ram_addr, ram_wr_data and ram_data_mask follow master g in GRANT and WR_BURST; they are 0 otherwise.
- ram_rd_data is forwarded unregistered to both mN_rd_data.
- A cmd_en from a non-owner, or while busy is high, is ignored: no RAM command and no state change.
- ram_rd_data_valid in IDLE or GRANT is dropped.
- Reset mid-burst: the arbiter returns to IDLE immediately. An in-flight RAM burst is not aborted. Any of its beats that arrive after reset are dropped.
- Counter wraps at COUNT. COUNT must be a power of two ≥ 1.

Decomposition:
- Shared package burst_ram_pkg:
  - BR_CMD_READ=1'b0, BR_CMD_WRITE=1'b1.
  - State encodings for arbiter states.
- One natural sub-module: rr_pick2. It is combinational; inputs req[1:0] and last_grant, output the winner. Everything else stays in the top module.

Test Plan:
- m0_req alone, read addr 4'h3; RAM returns 4 beats 0x11..0x44 → m0_rd_data_valid ×4 carrying those beats, m1_rd_data_valid stays 0, state back in IDLE after ram_busy falls.
- m0_req and m1_req rise in the same cycle after reset → m0 granted first. After m0 finishes and both request again, m1 is granted (alternation).
- m1 write addr 4'h7 with beats 0xA0..0xA3, mask 8'hFF → RAM sees cmd_en=1, cmd=1 with 0xA0, then 0xA1, 0xA2, 0xA3 on consecutive cycles; m0_busy=1 throughout.
- m0 holds req while m1 owns the bus, and m0 pulses cmd_en → no ram_cmd_en; m0 is granted only after DRAIN.
- ram_busy held high in GRANT for 5 cycles → mg_busy=1 and no cmd_en forwarded; the command is accepted on the first cycle ram_busy=0.
- rst asserted after 2 of 4 read beats → busy=1 at once, the next 2 beats are not forwarded, and a fresh m1 request is granted correctly.
